// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state encoding, S-box table and rcon helpers
// for the key-schedule blocks.
package aes_pkg;

  localparam int         AES128_NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_LAST = 8'h36;
  localparam logic [7:0] RCON_WRAP = 8'h1b;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  // Index 0 is the leftmost byte, so SBOX[x] is the substitution of x.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_WRAP : 8'h00);
  endfunction

  // Exact inverse of xtime over the rcon sequence: 1b is the only value
  // reached through the reduction, and it came from 80.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return (x == RCON_WRAP) ? 8'h80 : {1'b0, x[7:1]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single AES forward S-box, purely combinational table lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_subword.sv
// Key-schedule T-function: RotWord, four-way SubWord, then the rcon byte
// folded into the most-significant byte.
module aes_subword (
  input  logic [31:0] w_i,
  input  logic [7:0]  rcon_i,
  output logic [31:0] t_o
);

  logic [31:0] rot;
  logic [31:0] sub;

  assign rot = {w_i[23:0], w_i[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot[8*i +: 8]),
      .out_o (sub[8*i +: 8])
    );
  end

  assign t_o = sub ^ {rcon_i, 24'h000000};

endmodule

// File: rtl/inv_key_schedule.sv
// Reverse-order AES-128 round-key generator: expands forward to K10, then
// walks back K10..K0 one key per valid/ready handshake.
module inv_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         done
);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rc_q, rc_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  fw0, fw1, fw2, fw3;
  logic [31:0]  rw0, rw1, rw2, rw3;
  logic [31:0]  sub_in, t_word;
  logic [7:0]   rc_rev, sub_rcon;
  logic         handshake, last_fwd, last_key;

  assign {w0, w1, w2, w3} = key_q;
  assign rc_rev    = inv_xtime(rc_q);
  assign handshake = (state_q == OUTPUT) && key_ready;
  assign last_fwd  = (cnt_q == 4'(NR - 1));
  assign last_key  = (cnt_q == 4'd0);

  // One T-function serves both directions; the reverse step needs
  // T(w3 ^ w2), i.e. T of the already-recovered previous w3.
  assign sub_in   = (state_q == EXPAND) ? w3 : rw3;
  assign sub_rcon = (state_q == EXPAND) ? rc_q : rc_rev;

  aes_subword u_subword (
    .w_i    (sub_in),
    .rcon_i (sub_rcon),
    .t_o    (t_word)
  );

  assign fw0 = w0 ^ t_word;
  assign fw1 = w1 ^ fw0;
  assign fw2 = w2 ^ fw1;
  assign fw3 = w3 ^ fw2;

  assign rw3 = w3 ^ w2;
  assign rw2 = w2 ^ w1;
  assign rw1 = w1 ^ w0;
  assign rw0 = w0 ^ t_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = EXPAND;
      EXPAND:  if (last_fwd) state_d = OUTPUT;
      OUTPUT:  if (handshake && last_key) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cnt doubles as the presented round index once in OUTPUT.
  always_comb begin
    key_d  = key_q;
    rc_d   = rc_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d = key_in;
          rc_d  = RCON_INIT;
          cnt_d = '0;
        end
      end
      EXPAND: begin
        key_d = {fw0, fw1, fw2, fw3};
        rc_d  = xtime(rc_q);
        cnt_d = cnt_q + 4'd1;
      end
      OUTPUT: begin
        if (handshake) begin
          if (last_key) begin
            done_d = 1'b1;
          end else begin
            key_d = {rw0, rw1, rw2, rw3};
            rc_d  = rc_rev;
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    key_valid = (state_q == OUTPUT);
    round_key = key_q;
    round_idx = cnt_q;
    done      = done_q;
  end

  last_rcon_check: assert property (@(posedge clk) disable iff (rst)
    (state_q == EXPAND && last_fwd) |-> (rc_q == RCON_LAST));

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule using FIPS-197 and all-zero key vectors.
module tb_inv_key_schedule;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         done;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [127:0] fipsK [0:10];
  logic [127:0] zeroK [0:10];
  logic [127:0] expK  [0:10];
  logic [10:0]  knownMask;

  inv_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [127:0] k, input logic r);
    start     = s;
    key_in    = k;
    key_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " key_valid"}, 128'(key_valid), 128'(0));
    checkOutput({tag, " busy"},      128'(busy),      128'(0));
    checkOutput({tag, " done"},      128'(done),      128'(0));
    checkOutput({tag, " round_key"}, round_key,       128'(0));
    checkOutput({tag, " round_idx"}, 128'(round_idx), 128'(0));
  endtask

  // Walks K10..K0 from expK; a key must stay put until its handshake.
  task automatic walkKeys(input logic [31:0] pattern, input logic pulseStart, input string tag);
    int   idx;
    int   guard;
    logic rdy;
    idx   = 10;
    guard = 0;
    while (idx >= 0 && guard < 64) begin
      rdy = pattern[guard % 32];
      checkOutput({tag, " key_valid"}, 128'(key_valid), 128'(1));
      checkOutput({tag, " round_idx"}, 128'(round_idx), 128'(idx));
      if (knownMask[idx]) checkOutput({tag, " round_key"}, round_key, expK[idx]);
      start     = pulseStart ? guard[0] : 1'b0;
      key_in    = ~key_in;
      key_ready = rdy;
      tick();
      if (rdy) idx--;
      guard++;
    end
    checkOutput({tag, " walk finished"}, 128'(idx < 0), 128'(1));
    checkOutput({tag, " done pulse"},     128'(done),      128'(1));
    checkOutput({tag, " busy in done"},   128'(busy),      128'(0));
    checkOutput({tag, " valid in done"},  128'(key_valid), 128'(0));
  endtask

  initial begin
    fipsK[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fipsK[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fipsK[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fipsK[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fipsK[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fipsK[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fipsK[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fipsK[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fipsK[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fipsK[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fipsK[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 11; i++) zeroK[i] = '0;
    zeroK[1]  = 128'h62636363626363636263636362636363;
    zeroK[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    zeroK[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    zeroK[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    tick();
    checkIdle("reset");
    rst = 1'b0;
    tick();
    checkIdle("after reset release");

    $display("[TB] run A: FIPS key, ready high, start pulsed throughout");
    applyStimulus(1'b1, FIPS_KEY, 1'b1);
    tick();
    checkOutput("A busy after start",   128'(busy),      128'(1));
    checkOutput("A valid after start",  128'(key_valid), 128'(0));
    for (int i = 0; i < 9; i++) begin
      applyStimulus(i[0] ? 1'b0 : 1'b1, ~FIPS_KEY, 1'b1);
      tick();
    end
    checkOutput("A valid before E10", 128'(key_valid), 128'(0));
    tick();
    expK      = fipsK;
    knownMask = '1;
    walkKeys(32'hffff_ffff, 1'b1, "A");

    $display("[TB] run B: start in done cycle, FIPS key, ready toggled");
    applyStimulus(1'b1, FIPS_KEY, 1'b0);
    tick();
    checkOutput("B start accepted in done cycle", 128'(busy), 128'(1));
    checkOutput("B done single cycle",            128'(done), 128'(0));
    applyStimulus(1'b0, 128'h0123456789abcdef0123456789abcdef, 1'b0);
    repeat (10) tick();
    walkKeys(32'h9b3c_5a61, 1'b0, "B");
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    checkOutput("B done cleared", 128'(done), 128'(0));

    $display("[TB] run C: reset during EXPAND");
    applyStimulus(1'b1, '0, 1'b1);
    tick();
    start = 1'b0;
    repeat (5) tick();
    checkOutput("C busy mid expand", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    checkIdle("C async reset");
    tick();
    checkIdle("C reset edge");
    rst = 1'b0;
    tick();

    $display("[TB] run D: all-zero key full walk");
    applyStimulus(1'b1, '0, 1'b1);
    tick();
    start = 1'b0;
    repeat (10) tick();
    expK      = zeroK;
    knownMask = 11'b110_0000_0111;
    walkKeys(32'hffff_ffff, 1'b0, "D");

    $display("[TB] run E: reset during OUTPUT at idx 4");
    applyStimulus(1'b1, '0, 1'b1);
    tick();
    start = 1'b0;
    repeat (10) tick();
    checkOutput("E K10 zero key", round_key, zeroK[10]);
    repeat (6) tick();
    checkOutput("E idx before reset", 128'(round_idx), 128'(4));
    checkOutput("E valid before reset", 128'(key_valid), 128'(1));
    rst = 1'b1;
    #1;
    checkIdle("E async reset");
    tick();
    checkIdle("E reset edge");
    rst = 1'b0;
    tick();
    checkOutput("E no done after reset", 128'(done), 128'(0));

    $display("[TB] run F: fresh start after reset");
    applyStimulus(1'b1, FIPS_KEY, 1'b0);
    tick();
    start = 1'b0;
    repeat (10) tick();
    checkOutput("F K10",       round_key,        fipsK[10]);
    checkOutput("F idx 10",    128'(round_idx),  128'(10));
    checkOutput("F key_valid", 128'(key_valid),  128'(1));
    tick();
    checkOutput("F hold without ready", round_key, fipsK[10]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
